mc_control: RTL and testbench

MC_CONTROL -- requirements
Module: mc_control

---
 rtl/mc_control.sv | 166 ++++++++++++++++
 tb/tb_mc_control.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_control.sv
`timescale 1ns/1ps
// mc_control: multi-cycle CPU control unit (IF/ID/EXE/MEM/WB/HALT sequencer plus datapath decodes).
// Latency: j/illegal 2 cycles, beq 3, ALU-class 4, sw 4, lw 5; outputs are combinational from state and op.
// Backpressure: none; the sequencer advances every cycle, and HALT is left only through rst.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   op, zero   - instruction opcode (stable from end of IF), ALU zero flag (used only in EXE for beq)
//   state      - current state encoding
//   PCWre, IRWre, RegWre, DataMemRW - write enables (all forced low while rst is high)
//   ALUSrcB, ALUOp, RegDst, ALUM2Reg, ExtSel, PCSrc - datapath steering decodes
module mc_control (
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic       zero,
   output logic [2:0] state,
   output logic       PCWre,
   output logic       IRWre,
   output logic       ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       RegWre,
   output logic       RegDst,
   output logic       ALUM2Reg,
   output logic       DataMemRW,
   output logic       ExtSel,
   output logic [1:0] PCSrc
);

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b111
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_HALT = 6'b111111;

   state_t cur_state;
   state_t nxt_state;

   // opcode class decodes
   logic is_add, is_sub, is_addi, is_or, is_and, is_ori, is_sll, is_slt;
   logic is_sw, is_lw, is_beq, is_j, is_halt, is_alu;

   assign is_add  = (op == OP_ADD);
   assign is_sub  = (op == OP_SUB);
   assign is_addi = (op == OP_ADDI);
   assign is_or   = (op == OP_OR);
   assign is_and  = (op == OP_AND);
   assign is_ori  = (op == OP_ORI);
   assign is_sll  = (op == OP_SLL);
   assign is_slt  = (op == OP_SLT);
   assign is_sw   = (op == OP_SW);
   assign is_lw   = (op == OP_LW);
   assign is_beq  = (op == OP_BEQ);
   assign is_j    = (op == OP_J);
   assign is_halt = (op == OP_HALT);
   assign is_alu  = is_add | is_sub | is_addi | is_or | is_and | is_ori | is_sll | is_slt;

   // state-independent datapath steering
   assign ALUSrcB  = is_addi | is_ori | is_lw | is_sw;
   assign RegDst   = is_add | is_sub | is_or | is_and | is_sll | is_slt;
   assign ALUM2Reg = is_lw;
   assign ExtSel   = ~is_ori;
   assign state    = cur_state;

   always_comb begin
      ALUOp = 3'b000;
      if (is_sub | is_beq)     ALUOp = 3'b001;
      else if (is_slt)         ALUOp = 3'b010;
      else if (is_sll)         ALUOp = 3'b100;
      else if (is_or | is_ori) ALUOp = 3'b101;
      else if (is_and)         ALUOp = 3'b110;
   end

   always_ff @(posedge clk) begin
      if (rst) cur_state <= S_IF;
      else     cur_state <= nxt_state;
   end

   // next state and per-state enables; PCWre fires in the last state of each instruction
   always_comb begin
      nxt_state = S_IF;
      PCWre     = 1'b0;
      IRWre     = 1'b0;
      RegWre    = 1'b0;
      DataMemRW = 1'b0;
      PCSrc     = 2'b00;
      case (cur_state)
         S_IF: begin
            IRWre     = 1'b1;
            nxt_state = S_ID;
         end
         S_ID: begin
            if (is_alu | is_lw | is_sw | is_beq) begin
               nxt_state = S_EXE;
            end else if (is_halt) begin
               nxt_state = S_HALT;
            end else begin
               // j completes here; illegal opcodes retire as a nop
               nxt_state = S_IF;
               PCWre     = 1'b1;
               if (is_j) PCSrc = 2'b10;
            end
         end
         S_EXE: begin
            if (is_alu) begin
               nxt_state = S_WB;
            end else if (is_lw | is_sw) begin
               nxt_state = S_MEM;
            end else begin
               nxt_state = S_IF;
               if (is_beq) begin
                  PCWre = 1'b1;
                  if (zero) PCSrc = 2'b01;
               end
            end
         end
         S_MEM: begin
            if (is_lw) begin
               nxt_state = S_WB;
            end else begin
               nxt_state = S_IF;
               if (is_sw) begin
                  PCWre     = 1'b1;
                  DataMemRW = 1'b1;
               end
            end
         end
         S_WB: begin
            PCWre     = 1'b1;
            RegWre    = 1'b1;
            nxt_state = S_IF;
         end
         S_HALT: begin
            nxt_state = S_HALT;
         end
         default: begin
            nxt_state = S_IF;
         end
      endcase
      // write enables must stay quiet during the reset cycle, even mid-instruction
      if (rst) begin
         PCWre     = 1'b0;
         IRWre     = 1'b0;
         RegWre    = 1'b0;
         DataMemRW = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control.sv
`timescale 1ns/1ps
// tb_mc_control: directed per-cycle vectors with a scoreboard queue and a negedge monitor.
// Each row drives rst/op/zero just after a rising edge and queues the expected outputs for that cycle.
// Vector layout: {state[2:0], PCWre, IRWre, ALUSrcB, ALUOp[2:0], RegWre, RegDst, ALUM2Reg, DataMemRW, ExtSel, PCSrc[1:0]}
module tb_mc_control;

   localparam logic [2:0] S_IF = 3'b000, S_ID = 3'b001, S_EXE = 3'b010;
   localparam logic [2:0] S_MEM = 3'b011, S_WB = 3'b100, S_HALT = 3'b111;

   localparam logic [5:0] OP_ADD = 6'b000000, OP_SUB = 6'b000001, OP_AND = 6'b010001;
   localparam logic [5:0] OP_ORI = 6'b010010, OP_SLT = 6'b100110, OP_SW = 6'b110000;
   localparam logic [5:0] OP_LW = 6'b110001, OP_BEQ = 6'b110100, OP_J = 6'b111000;
   localparam logic [5:0] OP_HALT = 6'b111111, OP_ILL = 6'b000111;

   localparam logic [15:0] FM = 16'hFFFF; // all outputs checked
   localparam logic [15:0] RM = 16'h1848; // reset: PCWre, IRWre, RegWre, DataMemRW only
   localparam logic [15:0] HM = 16'hF84B; // halt: state, enables, PCSrc (decodes follow toggling op)

   logic       clk;
   logic       rst;
   logic [5:0] op;
   logic       zero;
   logic [2:0] state;
   logic       PCWre, IRWre, ALUSrcB, RegWre, RegDst, ALUM2Reg, DataMemRW, ExtSel;
   logic [2:0] ALUOp;
   logic [1:0] PCSrc;

   mc_control dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .zero      (zero),
      .state     (state),
      .PCWre     (PCWre),
      .IRWre     (IRWre),
      .ALUSrcB   (ALUSrcB),
      .ALUOp     (ALUOp),
      .RegWre    (RegWre),
      .RegDst    (RegDst),
      .ALUM2Reg  (ALUM2Reg),
      .DataMemRW (DataMemRW),
      .ExtSel    (ExtSel),
      .PCSrc     (PCSrc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard
   string       q_nm[$];
   logic [15:0] q_v[$];
   logic [15:0] q_m[$];
   int          checks = 0;
   int          errors = 0;

   // hand-set opcode-dependent expectations for the instruction in flight
   logic       d_srcb, d_regdst, d_m2r, d_ext;
   logic [2:0] d_aluop;

   task automatic set_dec(input logic srcb, input logic [2:0] aluop, input logic regdst,
                          input logic m2r, input logic ext);
      d_srcb = srcb; d_aluop = aluop; d_regdst = regdst; d_m2r = m2r; d_ext = ext;
   endtask

   task automatic step(input logic r, input logic [5:0] o, input logic z, input string nm,
                       input logic [2:0] st, input logic pcw, input logic irw, input logic regw,
                       input logic dmw, input logic [1:0] pcs, input logic [15:0] m);
      @(posedge clk);
      #1;
      rst  = r;
      op   = o;
      zero = z;
      q_nm.push_back(nm);
      q_v.push_back({st, pcw, irw, d_srcb, d_aluop, regw, d_regdst, d_m2r, dmw, d_ext, pcs});
      q_m.push_back(m);
   endtask

   // monitor: compares whatever the DUT presents against the oldest queued expectation
   always @(negedge clk) begin
      if (q_v.size() > 0) begin
         logic [15:0] act, ev, em;
         string nm;
         act = {state, PCWre, IRWre, ALUSrcB, ALUOp, RegWre, RegDst, ALUM2Reg, DataMemRW, ExtSel, PCSrc};
         nm  = q_nm.pop_front();
         ev  = q_v.pop_front();
         em  = q_m.pop_front();
         checks++;
         if (((act ^ ev) & em) !== 16'h0000) begin
            errors++;
            $display("FAIL %s: got %b required %b (mask %b)", nm, act, ev, em);
         end
      end
   end

   initial begin
      rst = 1'b1; op = OP_ADD; zero = 1'b0;
      set_dec(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);

      // reset: enables forced low
      step(1, OP_ADD, 0, "rst0", S_IF, 0, 0, 0, 0, 2'b00, RM);
      step(1, OP_ADD, 0, "rst1", S_IF, 0, 0, 0, 0, 2'b00, RM);

      // add: IF ID EXE WB
      set_dec(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
      step(0, OP_ADD, 0, "add_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_ADD, 1, "add_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_ADD, 1, "add_exe", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_ADD, 0, "add_wb",  S_WB,  1, 0, 1, 0, 2'b00, FM);

      // lw: IF ID EXE MEM WB
      set_dec(1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
      step(0, OP_LW, 0, "lw_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lw_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lw_exe", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lw_mem", S_MEM, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lw_wb",  S_WB,  1, 0, 1, 0, 2'b00, FM);

      // sw: IF ID EXE MEM
      set_dec(1'b1, 3'b000, 1'b0, 1'b0, 1'b1);
      step(0, OP_SW, 0, "sw_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_SW, 0, "sw_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_SW, 0, "sw_exe", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_SW, 0, "sw_mem", S_MEM, 1, 0, 0, 1, 2'b00, FM);

      // beq taken: zero high everywhere, only EXE cares
      set_dec(1'b0, 3'b001, 1'b0, 1'b0, 1'b1);
      step(0, OP_BEQ, 1, "beqt_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_BEQ, 1, "beqt_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_BEQ, 1, "beqt_exe", S_EXE, 1, 0, 0, 0, 2'b01, FM);
      // beq not taken
      step(0, OP_BEQ, 1, "beqn_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_BEQ, 1, "beqn_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_BEQ, 0, "beqn_exe", S_EXE, 1, 0, 0, 0, 2'b00, FM);

      // j and illegal retire in ID
      set_dec(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      step(0, OP_J,   1, "j_if",   S_IF, 0, 1, 0, 0, 2'b00, FM);
      step(0, OP_J,   1, "j_id",   S_ID, 1, 0, 0, 0, 2'b10, FM);
      step(0, OP_ILL, 1, "ill_if", S_IF, 0, 1, 0, 0, 2'b00, FM);
      step(0, OP_ILL, 1, "ill_id", S_ID, 1, 0, 0, 0, 2'b00, FM);

      // remaining ALU decodes: sub, ori (zero-extend), and, slt
      set_dec(1'b0, 3'b001, 1'b1, 1'b0, 1'b1);
      step(0, OP_SUB, 0, "sub_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_SUB, 0, "sub_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_SUB, 1, "sub_exe", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_SUB, 0, "sub_wb",  S_WB,  1, 0, 1, 0, 2'b00, FM);
      set_dec(1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
      step(0, OP_ORI, 0, "ori_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_ORI, 0, "ori_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_ORI, 0, "ori_exe", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_ORI, 0, "ori_wb",  S_WB,  1, 0, 1, 0, 2'b00, FM);
      set_dec(1'b0, 3'b110, 1'b1, 1'b0, 1'b1);
      step(0, OP_AND, 0, "and_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_AND, 0, "and_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_AND, 0, "and_exe", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_AND, 0, "and_wb",  S_WB,  1, 0, 1, 0, 2'b00, FM);
      set_dec(1'b0, 3'b010, 1'b1, 1'b0, 1'b1);
      step(0, OP_SLT, 0, "slt_if",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_SLT, 0, "slt_id",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_SLT, 0, "slt_exe", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_SLT, 0, "slt_wb",  S_WB,  1, 0, 1, 0, 2'b00, FM);

      // halt: sticky for 12 cycles while op/zero toggle
      set_dec(1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
      step(0, OP_HALT, 0, "halt_if", S_IF, 0, 1, 0, 0, 2'b00, FM);
      step(0, OP_HALT, 0, "halt_id", S_ID, 0, 0, 0, 0, 2'b00, FM);
      for (int i = 0; i < 12; i++) begin
         logic [5:0] hop;
         case (i % 5)
            0: hop = OP_J;
            1: hop = OP_BEQ;
            2: hop = OP_LW;
            3: hop = OP_ILL;
            default: hop = OP_SW;
         endcase
         step(0, hop, i[0], "halt_hold", S_HALT, 0, 0, 0, 0, 2'b00, HM);
      end
      step(1, OP_HALT, 1, "halt_rst", S_HALT, 0, 0, 0, 0, 2'b00, RM);

      // lw interrupted by reset in MEM: no WB, restart at IF
      set_dec(1'b1, 3'b000, 1'b0, 1'b1, 1'b1);
      step(0, OP_LW, 0, "lwr_if",   S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lwr_id",   S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lwr_exe",  S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(1, OP_LW, 0, "lwr_mem",  S_MEM, 0, 0, 0, 0, 2'b00, FM & ~16'h0000);
      step(0, OP_LW, 0, "lwr_if2",  S_IF,  0, 1, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lwr_id2",  S_ID,  0, 0, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lwr_exe2", S_EXE, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lwr_mem2", S_MEM, 0, 0, 0, 0, 2'b00, FM);
      step(0, OP_LW, 0, "lwr_wb2",  S_WB,  1, 0, 1, 0, 2'b00, FM);

      // drain: the monitor must have consumed every queued expectation
      @(negedge clk);
      #1;
      checks++;
      if (q_v.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending required 0", q_v.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // global watchdog so the run always ends
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout required completion");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
